// File: rtl/lc3_execute.sv
// LC3 execute stage: resolves bypassed operands, runs the ALU and the
// PC-relative address adder, and registers the results together with the
// forwarded control fields for the memaccess/writeback stages.
// Optional feature: define LC3_EXEC_ERR_EN to add the sticky exec_err output.
module lc3_execute #(
    parameter int DATA_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable_execute,
    input  logic [5:0]        e_control,
    input  logic              mem_control,
    input  logic [1:0]        w_control,
    input  logic [DATA_W-1:0] ir,
    input  logic [DATA_W-1:0] npc_out,
    input  logic [DATA_W-1:0] vsr1,
    input  logic [DATA_W-1:0] vsr2,
    input  logic              bypass_alu_1,
    input  logic              bypass_alu_2,
    input  logic              bypass_mem_1,
    input  logic              bypass_mem_2,
    input  logic [DATA_W-1:0] mem_bypass_val,
    output logic [DATA_W-1:0] aluout,
    output logic [DATA_W-1:0] pcout,
    output logic [2:0]        dr,
    output logic [DATA_W-1:0] ir_exec,
    output logic [2:0]        nzp,
    output logic [DATA_W-1:0] m_data,
    output logic              mem_control_out,
    output logic [1:0]        w_control_out,
    output logic [2:0]        sr1,
    output logic [2:0]        sr2
`ifdef LC3_EXEC_ERR_EN
    ,
    output logic              exec_err
`endif
);

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_AND = 2'b01;
    localparam logic [1:0] ALU_NOT = 2'b10;

    localparam logic [1:0] PCSEL_OFF11 = 2'b00;
    localparam logic [1:0] PCSEL_OFF9  = 2'b01;
    localparam logic [1:0] PCSEL_OFF6  = 2'b10;

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_STI = 4'b1011;
    localparam logic [3:0] OP_LEA = 4'b1110;

    // Sign extension of the instruction immediate/offset fields.
    function automatic logic signed [DATA_W-1:0] sext5(input logic [4:0] v);
        return {{(DATA_W-5){v[4]}}, v};
    endfunction

    function automatic logic signed [DATA_W-1:0] sext6(input logic [5:0] v);
        return {{(DATA_W-6){v[5]}}, v};
    endfunction

    function automatic logic signed [DATA_W-1:0] sext9(input logic [8:0] v);
        return {{(DATA_W-9){v[8]}}, v};
    endfunction

    function automatic logic signed [DATA_W-1:0] sext11(input logic [10:0] v);
        return {{(DATA_W-11){v[10]}}, v};
    endfunction

    // Decoded control fields.
    logic [1:0] alu_control;
    logic [1:0] pcselect1;
    logic       pcselect2;
    logic       op2select;
    logic [3:0] opcode;

    assign alu_control = e_control[5:4];
    assign pcselect1   = e_control[3:2];
    assign pcselect2   = e_control[1];
    assign op2select   = e_control[0];
    assign opcode      = ir[15:12];

    // Stage p0: combinational operand resolution, ALU and address adder.
    logic signed [DATA_W-1:0] operand1_p0;
    logic signed [DATA_W-1:0] operand2_p0;
    logic signed [DATA_W-1:0] op2_p0;
    logic signed [DATA_W-1:0] alu_res_p0;
    logic signed [DATA_W-1:0] addr_a_p0;
    logic signed [DATA_W-1:0] addr_b_p0;
    logic signed [DATA_W-1:0] pc_sum_p0;
    logic signed [DATA_W-1:0] result_p0;
    logic [2:0]               nzp_p0;

    // Register-source indices for hazard detection; stores read the source from ir[11:9].
    always_comb begin
        sr1 = ir[8:6];
        if (opcode == OP_ST || opcode == OP_STR || opcode == OP_STI) begin
            sr2 = ir[11:9];
        end else begin
            sr2 = ir[2:0];
        end
    end

    // Operand bypass muxes; the ALU bypass has priority over the memory bypass.
    always_comb begin
        if (bypass_alu_1) begin
            operand1_p0 = aluout;
        end else if (bypass_mem_1) begin
            operand1_p0 = mem_bypass_val;
        end else begin
            operand1_p0 = vsr1;
        end

        if (bypass_alu_2) begin
            operand2_p0 = aluout;
        end else if (bypass_mem_2) begin
            operand2_p0 = mem_bypass_val;
        end else begin
            operand2_p0 = vsr2;
        end

        op2_p0 = op2select ? operand2_p0 : sext5(ir[4:0]);
    end

    // ALU; the reserved encoding yields zero.
    always_comb begin
        case (alu_control)
            ALU_ADD: alu_res_p0 = operand1_p0 + op2_p0;
            ALU_AND: alu_res_p0 = operand1_p0 & op2_p0;
            ALU_NOT: alu_res_p0 = ~operand1_p0;
            default: alu_res_p0 = '0;
        endcase
    end

    // PC-relative address adder, wraps mod 2^DATA_W.
    always_comb begin
        case (pcselect1)
            PCSEL_OFF11: addr_a_p0 = sext11(ir[10:0]);
            PCSEL_OFF9:  addr_a_p0 = sext9(ir[8:0]);
            PCSEL_OFF6:  addr_a_p0 = sext6(ir[5:0]);
            default:     addr_a_p0 = '0;
        endcase
        addr_b_p0 = pcselect2 ? npc_out : operand1_p0;
        pc_sum_p0 = addr_a_p0 + addr_b_p0;
    end

    // LEA writes the computed address instead of the ALU result; branch mask only for BR.
    always_comb begin
        result_p0 = (opcode == OP_LEA) ? pc_sum_p0 : alu_res_p0;
        nzp_p0    = (opcode == OP_BR) ? ir[11:9] : 3'b000;
    end

    // Stage p1: registered results and forwarded control; hold when not enabled.
    always_ff @(posedge clock) begin
        if (reset) begin
            aluout          <= '0;
            pcout           <= '0;
            dr              <= '0;
            ir_exec         <= '0;
            nzp             <= '0;
            m_data          <= '0;
            mem_control_out <= 1'b0;
            w_control_out   <= '0;
        end else if (enable_execute) begin
            aluout          <= result_p0;
            pcout           <= pc_sum_p0;
            dr              <= ir[11:9];
            ir_exec         <= ir;
            nzp             <= nzp_p0;
            m_data          <= operand2_p0;
            mem_control_out <= mem_control;
            w_control_out   <= w_control;
        end
    end

`ifdef LC3_EXEC_ERR_EN
    logic err_cond_p0;

    assign err_cond_p0 = (alu_control == 2'b11) ||
                         (bypass_alu_1 && bypass_mem_1) ||
                         (bypass_alu_2 && bypass_mem_2);

    // Sticky error flag: set on an enabled edge with an illegal condition, cleared only by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            exec_err <= 1'b0;
        end else if (enable_execute && err_cond_p0) begin
            exec_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_lc3_execute.sv
// Bench for lc3_execute: directed cases plus a random run, with expected
// register contents pushed to a scoreboard queue before each edge.
module tb_lc3_execute;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable_execute;
    logic [5:0]  e_control;
    logic        mem_control;
    logic [1:0]  w_control;
    logic [15:0] ir, npc_out, vsr1, vsr2, mem_bypass_val;
    logic        bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2;
    logic [15:0] aluout, pcout, ir_exec, m_data;
    logic [2:0]  dr, nzp, sr1, sr2;
    logic        mem_control_out;
    logic [1:0]  w_control_out;
`ifdef LC3_EXEC_ERR_EN
    logic        exec_err;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [15:0] alu;
        logic [15:0] pc;
        logic [2:0]  dr;
        logic [15:0] irx;
        logic [2:0]  nzp;
        logic [15:0] md;
        logic        mc;
        logic [1:0]  wc;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    exp_t state = '0;

    lc3_execute #(.DATA_W(16)) dut (
        .clock(clock), .reset(reset), .enable_execute(enable_execute),
        .e_control(e_control), .mem_control(mem_control), .w_control(w_control),
        .ir(ir), .npc_out(npc_out), .vsr1(vsr1), .vsr2(vsr2),
        .bypass_alu_1(bypass_alu_1), .bypass_alu_2(bypass_alu_2),
        .bypass_mem_1(bypass_mem_1), .bypass_mem_2(bypass_mem_2),
        .mem_bypass_val(mem_bypass_val),
        .aluout(aluout), .pcout(pcout), .dr(dr), .ir_exec(ir_exec), .nzp(nzp),
        .m_data(m_data), .mem_control_out(mem_control_out),
        .w_control_out(w_control_out), .sr1(sr1), .sr2(sr2)
`ifdef LC3_EXEC_ERR_EN
        , .exec_err(exec_err)
`endif
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model of the next registered state.
    function automatic exp_t model_next(exp_t cur);
        exp_t n;
        logic [15:0] o1, o2, b, a, pc, res;
        if (reset) return '0;
        if (!enable_execute) return cur;
        o1 = bypass_alu_1 ? cur.alu : (bypass_mem_1 ? mem_bypass_val : vsr1);
        o2 = bypass_alu_2 ? cur.alu : (bypass_mem_2 ? mem_bypass_val : vsr2);
        b  = e_control[0] ? o2 : {{11{ir[4]}}, ir[4:0]};
        case (e_control[5:4])
            2'd0: res = o1 + b;
            2'd1: res = o1 & b;
            2'd2: res = ~o1;
            default: res = 16'h0000;
        endcase
        case (e_control[3:2])
            2'd0: a = {{5{ir[10]}}, ir[10:0]};
            2'd1: a = {{7{ir[8]}}, ir[8:0]};
            2'd2: a = {{10{ir[5]}}, ir[5:0]};
            default: a = 16'h0000;
        endcase
        pc = a + (e_control[1] ? npc_out : o1);
        n.alu = (ir[15:12] == 4'hE) ? pc : res;
        n.pc  = pc;
        n.dr  = ir[11:9];
        n.irx = ir;
        n.nzp = (ir[15:12] == 4'h0) ? ir[11:9] : 3'b000;
        n.md  = o2;
        n.mc  = mem_control;
        n.wc  = w_control;
        n.err = cur.err | (e_control[5:4] == 2'b11) |
                (bypass_alu_1 & bypass_mem_1) | (bypass_alu_2 & bypass_mem_2);
        return n;
    endfunction

    // One clock: push expected state, advance, pop and compare every registered output.
    task automatic step();
        exp_t e;
        sb_q.push_back(model_next(state));
        @(posedge clock);
        #1;
        e = sb_q.pop_front();
        check_val("aluout", aluout, e.alu);
        check_val("pcout", pcout, e.pc);
        check_val("dr", {13'd0, dr}, {13'd0, e.dr});
        check_val("ir_exec", ir_exec, e.irx);
        check_val("nzp", {13'd0, nzp}, {13'd0, e.nzp});
        check_val("m_data", m_data, e.md);
        check_val("mem_ctl", {15'd0, mem_control_out}, {15'd0, e.mc});
        check_val("w_ctl", {14'd0, w_control_out}, {14'd0, e.wc});
`ifdef LC3_EXEC_ERR_EN
        check_val("exec_err", {15'd0, exec_err}, {15'd0, e.err});
`endif
        state = e;
    endtask

    task automatic set_in(input logic [15:0] i, input logic [5:0] ec,
                          input logic [15:0] v1, input logic [15:0] v2);
        ir = i; e_control = ec; vsr1 = v1; vsr2 = v2;
        bypass_alu_1 = 0; bypass_alu_2 = 0; bypass_mem_1 = 0; bypass_mem_2 = 0;
        enable_execute = 1; reset = 0;
    endtask

    initial begin
        reset = 1; enable_execute = 1; e_control = 0; mem_control = 0; w_control = 0;
        ir = 0; npc_out = 16'h3000; vsr1 = 0; vsr2 = 0; mem_bypass_val = 0;
        bypass_alu_1 = 0; bypass_alu_2 = 0; bypass_mem_1 = 0; bypass_mem_2 = 0;
        @(negedge clock);
        step();
        step();
        check_val("rst_alu", aluout, 16'h0000);

        // ADD R3,R1,R2
        set_in(16'h1642, 6'b000001, 16'd5, 16'd7);
        mem_control = 1; w_control = 2'b10;
        #1;
        check_val("sr1_add", {13'd0, sr1}, 16'd1);
        check_val("sr2_add", {13'd0, sr2}, 16'd2);
        step();
        check_val("t1_alu", aluout, 16'd12);
        check_val("t1_dr", {13'd0, dr}, 16'd3);
        check_val("t1_mdata", m_data, 16'd7);

        // Dependent ADD through ALU bypass on operand1
        bypass_alu_1 = 1;
        step();
        check_val("byp_alu1", aluout, 16'd19);

        // Dual bypass on operand2: ALU value wins over memory value
        bypass_alu_1 = 0; bypass_alu_2 = 1; bypass_mem_2 = 1; mem_bypass_val = 16'd100;
        step();
        check_val("dual_byp_alu", aluout, 16'd24);
        check_val("dual_byp_md", m_data, 16'd19);

        // Hold for three cycles with changing inputs
        enable_execute = 0;
        for (int k = 0; k < 3; k++) begin
            ir = 16'($urandom); vsr1 = 16'($urandom); e_control = 6'($urandom);
            step();
            check_val("hold_alu", aluout, 16'd24);
        end

        // ADD immediate: 5 + (-3)
        set_in(16'h167D, 6'b000000, 16'd5, 16'd0);
        mem_control = 0; w_control = 2'b01;
        step();
        check_val("addi", aluout, 16'd2);

        // BRz -2
        set_in(16'h05FE, 6'b000110, 16'd0, 16'd0);
        npc_out = 16'h3001;
        step();
        check_val("br_pc", pcout, 16'h2FFF);
        check_val("br_nzp", {13'd0, nzp}, 16'd2);

        // LEA R0,#5 -> aluout takes the address
        set_in(16'hE005, 6'b000110, 16'h1111, 16'd0);
        npc_out = 16'h3000;
        step();
        check_val("lea_alu", aluout, 16'h3005);

        // LDR-style base+offset6 with memory bypass on the base
        set_in(16'h6A7F, 6'b001000, 16'h1234, 16'd0);
        bypass_mem_1 = 1; mem_bypass_val = 16'h4000;
        step();
        check_val("ldr_pc", pcout, 16'h3FFF);

        // STR: sr2 comes from ir[11:9]; pcselect1=11 gives base only
        set_in(16'h7A41, 6'b001100, 16'h0200, 16'hBEEF);
        #1;
        check_val("sr2_str", {13'd0, sr2}, 16'd5);
        step();
        check_val("str_pc", pcout, 16'h0200);
        check_val("str_md", m_data, 16'hBEEF);

        // AND, NOT, add overflow
        set_in(16'h5642, 6'b010001, 16'hF0F0, 16'h3C3C);
        step();
        check_val("and", aluout, 16'h3030);
        set_in(16'h967F, 6'b100000, 16'hF0F0, 16'd0);
        step();
        check_val("not", aluout, 16'h0F0F);
        set_in(16'h1642, 6'b000001, 16'hFFFF, 16'h0002);
        step();
        check_val("add_wrap", aluout, 16'h0001);

        // Reserved ALU encoding
        set_in(16'h1642, 6'b110000, 16'd5, 16'd7);
        step();
        check_val("rsvd_alu", aluout, 16'h0000);
`ifdef LC3_EXEC_ERR_EN
        check_val("err_set", {15'd0, exec_err}, 16'd1);
        set_in(16'h1642, 6'b000001, 16'd1, 16'd1);
        step();
        check_val("err_sticky", {15'd0, exec_err}, 16'd1);
`endif

        // Reset while an ADD is enabled, then release
        set_in(16'h1642, 6'b000001, 16'd5, 16'd7);
        reset = 1;
        step();
        check_val("rst_mid_alu", aluout, 16'h0000);
        check_val("rst_mid_ir", ir_exec, 16'h0000);
`ifdef LC3_EXEC_ERR_EN
        check_val("err_clr", {15'd0, exec_err}, 16'd0);
`endif
        reset = 0;
        step();
        check_val("post_rst_alu", aluout, 16'd12);

        // Random traffic against the model
        for (int k = 0; k < 200; k++) begin
            reset = ($urandom_range(0, 31) == 0);
            enable_execute = ($urandom_range(0, 3) != 0);
            e_control = 6'($urandom);
            mem_control = 1'($urandom);
            w_control = 2'($urandom);
            ir = 16'($urandom); npc_out = 16'($urandom);
            vsr1 = 16'($urandom); vsr2 = 16'($urandom);
            mem_bypass_val = 16'($urandom);
            bypass_alu_1 = 1'($urandom); bypass_alu_2 = 1'($urandom);
            bypass_mem_1 = 1'($urandom); bypass_mem_2 = 1'($urandom);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lc3_execute.md
Name: lc3_execute

Overview:
- LC3 pipeline execute stage, directly downstream of decode; consumes the decode_out bundle (e_control, mem_control, w_control, ir, npc_out).
- Resolves operands through ALU/memory bypass muxes.
- Computes the ALU result and the PC-relative address.
- Registers the results, together with the forwarded control fields, for the memaccess/writeback stages.

Parameters:
- DATA_W, 16, datapath width. Fixed 16 for LC3; other values are unsupported.

Ports:
- clock  in  1  stage clock, rising edge
- reset  in  1  synchronous, active-high
- enable_execute  in  1  stage advance; 0 = hold all registered outputs
- e_control  in  6  {alu_control[1:0], pcselect1[1:0], pcselect2, op2select}
- mem_control  in  1  forwarded unchanged to mem_control_out
- w_control  in  2  forwarded unchanged to w_control_out
- ir  in  16  instruction from decode
- npc_out  in  16  next PC from decode
- vsr1  in  16  register-file read of sr1
- vsr2  in  16  register-file read of sr2
- bypass_alu_1  in  1  operand1 takes aluout
- bypass_alu_2  in  1  operand2 takes aluout
- bypass_mem_1  in  1  operand1 takes mem_bypass_val
- bypass_mem_2  in  1  operand2 takes mem_bypass_val
- mem_bypass_val  in  16  memory-stage forwarded data
- aluout  out  16  registered ALU result
- pcout  out  16  registered address-adder result
- dr  out  3  registered ir[11:9]
- ir_exec  out  16  registered ir
- nzp  out  3  registered branch mask: ir[11:9] if opcode=0000, else 000
- m_data  out  16  registered resolved operand2 (store data)
- mem_control_out  out  1  registered
- w_control_out  out  2  registered
- sr1  out  3  combinational ir[8:6]
- sr2  out  3  combinational: ir[11:9] if opcode ∈ {0011, 0111, 1011}, else ir[2:0]

Behaviour:
- Single clock, clock; reset synchronous, active-high. No other state elements.
- Reset: every registered output is 0 on the next rising edge. Reset overrides enable_execute and any in-flight operands.
- Latency: 1 cycle. Inputs sampled at the edge with enable_execute=1 appear on the outputs after that edge. With enable_execute=0, registered outputs hold.
- sr1/sr2 are combinational from the ir input (zero latency) for hazard detection.
- Operand1 = bypass_alu_1 ? aluout : bypass_mem_1 ? mem_bypass_val : vsr1. ALU bypass wins when both bypasses are set. Operand2 is resolved identically with the _2 signals.
- op2 = op2select ? operand2 : sext(ir[4:0]).
- alu_control encoding: 00 ADD (operand1+op2, mod 2^16, carry dropped); 01 AND; 10 NOT operand1; 11 reserved, aluout=0.
- Address adder, mod 2^16:
  - term A: pcselect1 00=sext(ir[10:0]), 01=sext(ir[8:0]), 10=sext(ir[5:0]), 11=0
  - term B: pcselect2 1=npc_out, 0=operand1
  - pcout = A + B
- LEA (opcode 1110): aluout = pcout value, not the ALU result.
- m_data = operand2 after bypass resolution, captured every enabled cycle.
- Back-to-back dependent instructions: bypass_alu_x uses the aluout value registered at the previous edge.

Optional Feature:
- Macro: LC3_EXEC_ERR_EN.
- Defined: adds output exec_err (1 bit, sticky, reset to 0). It is set on an enabled edge when either:
  - alu_control=11, or
  - bypass_alu_x and bypass_mem_x are both asserted for the same operand.
  Only reset clears it.
- Undefined: port and logic are absent. The reserved encoding still yields aluout=0; dual bypass still resolves with ALU priority.

Test Plan:
1. ADD R3,R1,R2: ir=16'h1642, e_control=6'b000001, vsr1=5, vsr2=7, enable=1 -> next cycle aluout=12, dr=3, m_data=7, nzp=000; sr1=1, sr2=2 combinationally.
2. ADD immediate: ir=16'h167D, e_control=6'b000000, vsr1=5 -> aluout=2 (5+(-3)).
3. BRz -2: ir=16'h05FE, npc_out=16'h3001, e_control=6'b000110 -> pcout=16'h2FFF, nzp=3'b010.
4. Bypass and hold:
   - Repeat case 1 with bypass_alu_1=1 in the next cycle -> aluout=19.
   - Assert bypass_alu_2 and bypass_mem_2 together, mem_bypass_val=100 -> operand2 = aluout.
   - Then enable_execute=0 for 3 cycles -> all outputs hold.
5. Reset mid-operation: reset=1 on the cycle ADD is enabled -> all registered outputs are 0 after the edge.
   - Then apply reset=0 with the same ADD -> aluout=12 one cycle later.
6. With LC3_EXEC_ERR_EN defined: e_control=6'b110000 with enable=1 -> aluout=0, exec_err=1.
   - exec_err holds 1 through subsequent legal ops; clears only on reset.
